// File: rtl/platform_boot_stream_ctrl.sv
// platform_boot_stream_ctrl
// Loads a program image into the platform ROM, sequences the platform
// reset, feeds din_req from a small input FIFO and captures dout words.
// Optional feature: define PBSC_CKSUM_EN to add a 16-bit image checksum
// output (cksum); without it the port and the adder are absent.
module platform_boot_stream_ctrl #(
  parameter int ADDR_W    = 14,
  parameter int ROM_DEPTH = 16384,
  parameter int BYTE_W    = 8,
  parameter int DATA_W    = 32,
  parameter int IN_DEPTH  = 4,
  parameter int RST_CYC   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] img_data,
  input  logic              img_valid,
  output logic              img_ready,
  output logic [ADDR_W-1:0] sw_addr,
  output logic [BYTE_W-1:0] sw_din,
  output logic              we_n,
  output logic              mode,
  output logic              plat_rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] din,
  output logic              din_rdy,
  input  logic              din_req,
  input  logic [DATA_W-1:0] dout,
  input  logic              dout_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
`ifdef PBSC_CKSUM_EN
  output logic [15:0]       cksum,
`endif
  output logic              load_done,
  output logic              starve
);

  localparam int PTR_W  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int RCNT_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);
  localparam logic [RCNT_W-1:0] LAST_RCNT = RCNT_W'(RST_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RESET,
    S_RUN
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [RCNT_W-1:0]   rst_cnt;
  logic                dout_rdy_q;

  // Input FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [DATA_W-1:0]   fifo_mem [IN_DEPTH];
  logic [PTR_W:0]      wr_ptr;
  logic [PTR_W:0]      rd_ptr;
  logic                fifo_empty;
  logic                fifo_full;

  logic                img_accept;
  logic                restart;
  logic                push;
  logic                serve;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign img_ready  = (state == S_LOAD);
  assign in_ready   = !fifo_full;
  assign img_accept = img_ready && img_valid;
  // A start pulse is honoured only from IDLE or RUN; it flushes the FIFO,
  // so a push arriving on that same cycle is dropped.
  assign restart    = start && ((state == S_IDLE) || (state == S_RUN));
  assign push       = in_valid && !fifo_full && !restart;
  assign serve      = (state == S_RUN) && !restart && din_req && !din_rdy && !fifo_empty;

  // FIFO storage write.
  // NOTE: storage arrays carry no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= in_data;
    end
  end

  // Sequencer FSM with all registered outputs, FIFO pointers and counters.
  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rst_cnt    <= '0;
      dout_rdy_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sw_addr    <= '0;
      sw_din     <= '0;
      we_n       <= 1'b1;
      mode       <= 1'b0;
      plat_rst   <= 1'b1;
      din        <= '0;
      din_rdy    <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      load_done  <= 1'b0;
      starve     <= 1'b0;
`ifdef PBSC_CKSUM_EN
      cksum      <= '0;
`endif
    end else begin
      we_n       <= 1'b1;
      out_valid  <= 1'b0;
      dout_rdy_q <= dout_rdy;
      if (push)  wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      if (serve) rd_ptr <= rd_ptr + (PTR_W + 1)'(1);

      if (restart) begin
        // Entry to LOAD: clear everything tied to the previous image/run.
        state     <= S_LOAD;
        mode      <= 1'b1;
        plat_rst  <= 1'b1;
        load_done <= 1'b0;
        cnt       <= '0;
        starve    <= 1'b0;
        din_rdy   <= 1'b0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
`ifdef PBSC_CKSUM_EN
        cksum     <= '0;
`endif
      end else begin
        case (state)
          S_LOAD: begin
            if (img_accept) begin
              sw_addr <= cnt;
              sw_din  <= img_data;
              we_n    <= 1'b0;
`ifdef PBSC_CKSUM_EN
              cksum   <= cksum + 16'(img_data);
`endif
              if (cnt == LAST_ADDR) begin
                state     <= S_RESET;
                mode      <= 1'b0;
                load_done <= 1'b1;
                rst_cnt   <= '0;
              end else begin
                cnt <= cnt + ADDR_W'(1);
              end
            end
          end
          S_RESET: begin
            if (rst_cnt == LAST_RCNT) begin
              state    <= S_RUN;
              plat_rst <= 1'b0;
            end else begin
              rst_cnt <= rst_cnt + RCNT_W'(1);
            end
          end
          S_RUN: begin
            if (din_req && !din_rdy) begin
              if (!fifo_empty) begin
                din     <= fifo_mem[rd_ptr[PTR_W-1:0]];
                din_rdy <= 1'b1;
              end else begin
                starve  <= 1'b1;
              end
            end else if (!din_req && din_rdy) begin
              din_rdy <= 1'b0;
            end
            if (dout_rdy && !dout_rdy_q) begin
              out_data  <= dout;
              out_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
